// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - replays a solved knight's tour as vertical/horizontal move commands, else passes UART commands through
module tour_cmd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [3:0] OP_VERT   = 4'h2;
  localparam logic [3:0] OP_HORZ   = 4'h3;
  localparam logic [7:0] HD_NORTH  = 8'h00;
  localparam logic [7:0] HD_WEST   = 8'h3F;
  localparam logic [7:0] HD_SOUTH  = 8'h7F;
  localparam logic [7:0] HD_EAST   = 8'hBF;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ACK  = 8'h5A;
  localparam logic [4:0] LAST_MOVE = 5'd23;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    VERT   = 3'd2,
    WAIT_V = 3'd3,
    HORZ   = 3'd4,
    WAIT_H = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] mv_indx_q, mv_indx_d;

  logic [7:0] vert_head, horz_head;
  logic [3:0] vert_sq, horz_sq;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  // Decode the one-hot knight move into two straight legs; anything not one-hot becomes a null move
  always_comb begin
    vert_head = HD_NORTH;
    vert_sq   = 4'h0;
    horz_head = HD_NORTH;
    horz_sq   = 4'h0;
    case (move)
      8'h01: begin vert_head = HD_NORTH; vert_sq = 4'd2; horz_head = HD_WEST; horz_sq = 4'd1; end
      8'h02: begin vert_head = HD_NORTH; vert_sq = 4'd2; horz_head = HD_EAST; horz_sq = 4'd1; end
      8'h04: begin vert_head = HD_NORTH; vert_sq = 4'd1; horz_head = HD_WEST; horz_sq = 4'd2; end
      8'h08: begin vert_head = HD_SOUTH; vert_sq = 4'd1; horz_head = HD_WEST; horz_sq = 4'd2; end
      8'h10: begin vert_head = HD_SOUTH; vert_sq = 4'd2; horz_head = HD_WEST; horz_sq = 4'd1; end
      8'h20: begin vert_head = HD_SOUTH; vert_sq = 4'd2; horz_head = HD_EAST; horz_sq = 4'd1; end
      8'h40: begin vert_head = HD_SOUTH; vert_sq = 4'd1; horz_head = HD_EAST; horz_sq = 4'd2; end
      8'h80: begin vert_head = HD_NORTH; vert_sq = 4'd1; horz_head = HD_EAST; horz_sq = 4'd2; end
      default: begin
        vert_head = HD_NORTH;
        vert_sq   = 4'h0;
        horz_head = HD_NORTH;
        horz_sq   = 4'h0;
      end
    endcase
  end

  assign vert_cmd  = {OP_VERT, vert_head, vert_sq};
  assign horz_cmd  = {OP_HORZ, horz_head, horz_sq};
  assign last_move = (mv_indx_q == LAST_MOVE);
  assign mv_indx   = mv_indx_q;

  // Next-state and output decode; IDLE hands the command path to the UART, other states own it
  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_ACK;
    case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          mv_indx_d = 5'd0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // one dead cycle while the solver's registered read presents the new move
        state_d = VERT;
      end
      VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_V;
      end
      WAIT_V: begin
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd = horz_cmd;
        if (last_move) resp = RESP_DONE;
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + 5'd1;
            state_d   = FETCH;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and move-index registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - scoreboard bench for tour_cmd
module tb_tour_cmd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  moves_mem [32];

  tour_cmd dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  always #5 clk = ~clk;

  // Solver model: registered read of the move table, one clock behind mv_indx
  always @(posedge clk) move <= moves_mem[mv_indx];

  function automatic logic [15:0] model_leg(input logic [7:0] m, input bit vert);
    int dx, dy;
    logic [3:0] op;
    op = vert ? 4'h2 : 4'h3;
    dx = 0; dy = 0;
    if ($countones(m) != 1) return {op, 12'h000};
    case (m)
      8'h01: begin dx = -1; dy =  2; end
      8'h02: begin dx =  1; dy =  2; end
      8'h04: begin dx = -2; dy =  1; end
      8'h08: begin dx = -2; dy = -1; end
      8'h10: begin dx = -1; dy = -2; end
      8'h20: begin dx =  1; dy = -2; end
      8'h40: begin dx =  2; dy = -1; end
      default: begin dx = 2; dy = 1; end
    endcase
    if (vert) return {op, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    return {op, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_timeout", 16'(cmd_rdy), 16'd1);
  endtask

  task automatic pop_chk(input string tag);
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 16'(exp_q.size()), 16'd1);
    else chk(tag, cmd, exp_q.pop_front());
  endtask

  // mode 0: normal move; 1: also inject stray signals; 2: stop in WAIT_V
  task automatic run_move(input int idx, input int mode);
    logic [15:0] ev;
    int n;
    ev = model_leg(moves_mem[idx], 1'b1);
    exp_q.push_back(ev);
    exp_q.push_back(model_leg(moves_mem[idx], 1'b0));
    wait_rdy(n);
    chk("fetch_len", 16'(n), 16'd1);
    pop_chk("v_cmd");
    chk("v_mv_indx", 16'(mv_indx), 16'(idx));
    chk("v_resp", 16'(resp), 16'h005A);
    if (mode == 1) begin
      send_resp = 1'b1; start_tour = 1'b1;
      @(negedge clk);
      send_resp = 1'b0; start_tour = 1'b0;
      chk("stray_v_rdy", 16'(cmd_rdy), 16'd1);
      chk("stray_v_cmd", cmd, ev);
      chk("stray_v_idx", 16'(mv_indx), 16'(idx));
    end
    clr_cmd_rdy = 1'b1;
    #1 chk("v_clr_uart", 16'(clr_cmd_rdy_UART), 16'd0);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("wv_rdy", 16'(cmd_rdy), 16'd0);
    chk("wv_cmd", cmd, ev);
    if (mode == 1) begin
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      chk("stray_wv_rdy", 16'(cmd_rdy), 16'd0);
    end
    if (mode == 2) return;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    wait_rdy(n);
    chk("h_latency", 16'(n), 16'd0);
    pop_chk("h_cmd");
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("wh_rdy", 16'(cmd_rdy), 16'd0);
    chk("wh_resp", 16'(resp), (idx == 23) ? 16'h00A5 : 16'h005A);
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    if (idx != 23) begin
      chk("fetch_rdy", 16'(cmd_rdy), 16'd0);
      chk("fetch_idx", 16'(mv_indx), 16'(idx + 1));
    end
  endtask

  task automatic begin_tour();
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
    chk("start_idx", 16'(mv_indx), 16'd0);
    chk("start_rdy", 16'(cmd_rdy), 16'd0);
  endtask

  initial begin
    rst = 1'b1; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0; move = 8'h00;
    for (int i = 0; i < 32; i++) moves_mem[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    chk("rst_idx", 16'(mv_indx), 16'd0);
    chk("rst_resp", 16'(resp), 16'h00A5);
    chk("rst_cmd", cmd, 16'h1234);
    chk("rst_rdy", 16'(cmd_rdy), 16'd0);
    rst = 1'b0;

    // UART pass-through in IDLE
    cmd_UART = 16'h2013; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
    #1;
    chk("pt_cmd", cmd, 16'h2013);
    chk("pt_rdy", 16'(cmd_rdy), 16'd1);
    chk("pt_clr", 16'(clr_cmd_rdy_UART), 16'd1);
    chk("pt_resp", 16'(resp), 16'h00A5);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    #1 chk("pt_clr_off", 16'(clr_cmd_rdy_UART), 16'd0);
    @(negedge clk);

    // Single move 8'h02, checked against literal command words
    moves_mem[0] = 8'h02;
    begin_tour();
    exp_q.push_back(16'h2002);
    exp_q.push_back(16'h3BF1);
    run_move(0, 0);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("single_rst_idx", 16'(mv_indx), 16'd0);
    chk("single_rst_cmd", cmd, 16'h2013);

    // Full tour: decode sweep, illegal/zero moves, then random legal moves
    for (int i = 0; i < 8; i++) moves_mem[i] = 8'(1 << i);
    moves_mem[8] = 8'h03;
    moves_mem[9] = 8'h00;
    moves_mem[10] = 8'hC0;
    for (int i = 11; i < 24; i++) moves_mem[i] = 8'(1 << $urandom_range(0, 7));
    begin_tour();
    for (int i = 0; i < 24; i++) run_move(i, (i == 8) ? 1 : 0);
    chk("tour_end_resp", 16'(resp), 16'h00A5);
    chk("tour_end_cmd", cmd, 16'h2013);
    chk("tour_end_rdy", 16'(cmd_rdy), 16'd1);
    chk("tour_end_idx", 16'(mv_indx), 16'd23);
    chk("tour_sb_empty", 16'(exp_q.size()), 16'd0);

    // Reset in WAIT_V at move 7, with a competing send_resp
    begin_tour();
    for (int i = 0; i < 7; i++) run_move(i, 0);
    run_move(7, 2);
    chk("pre_rst_idx", 16'(mv_indx), 16'd7);
    rst = 1'b1; send_resp = 1'b1;
    @(negedge clk);
    rst = 1'b0; send_resp = 1'b0;
    exp_q.delete();
    chk("mid_rst_idx", 16'(mv_indx), 16'd0);
    chk("mid_rst_resp", 16'(resp), 16'h00A5);
    chk("mid_rst_cmd", cmd, 16'h2013);
    chk("mid_rst_rdy", 16'(cmd_rdy), 16'd1);
    clr_cmd_rdy = 1'b1;
    #1 chk("mid_rst_clr", 16'(clr_cmd_rdy_UART), 16'd1);
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    chk("idle_hold_resp", 16'(resp), 16'h00A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tour_cmd.md
TOUR_CMD -- requirements
Module: tour_cmd

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start_tour  in  1  one-cycle pulse from tour solver done; begins tour replay.
REQ-004 SHALL have port: move  in  8  one-hot knight move for mv_indx; valid 1 clk after mv_indx changes.
REQ-005 SHALL have port: mv_indx  out  5  index (0-23) of move being fetched from solver.
REQ-006 SHALL have port: cmd_UART  in  16  command from UART wrapper.
REQ-007 SHALL have port: cmd_rdy_UART  in  1  UART command valid.
REQ-008 SHALL have port: clr_cmd_rdy_UART  out  1  consume strobe back to UART wrapper.
REQ-009 SHALL have port: cmd  out  16  command to command processor.
REQ-010 SHALL have port: cmd_rdy  out  1  cmd valid.
REQ-011 SHALL have port: clr_cmd_rdy  in  1  command processor accepted cmd.
REQ-012 SHALL have port: send_resp  in  1  command processor finished current cmd.
REQ-013 SHALL have port: resp  out  8  response byte to UART.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, VERT, WAIT_V, HORZ, WAIT_H.
REQ-015 IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy (combinational pass-through).
REQ-016 In every non-IDLE state, cmd_rdy_UART SHALL be ignored and clr_cmd_rdy_UART SHALL be 0.
REQ-017 IDLE + start_tour: mv_indx<=0, next FETCH; start_tour SHALL be ignored outside IDLE.
REQ-018 FETCH: lasts exactly 1 clk (covers solver's registered read latency), cmd_rdy=0, next VERT.
REQ-019 VERT: cmd_rdy=1, cmd=vertical leg; on clr_cmd_rdy -> WAIT_V, else hold.
REQ-020 WAIT_V: cmd_rdy=0, cmd holds vertical leg; on send_resp -> HORZ.
REQ-021 HORZ: cmd_rdy=1, cmd=horizontal leg; on clr_cmd_rdy -> WAIT_H.
REQ-022 WAIT_H + send_resp: if mv_indx==23 -> IDLE, else mv_indx<=mv_indx+1 and -> FETCH.
REQ-023 send_resp in VERT/HORZ and clr_cmd_rdy in WAIT_V/WAIT_H SHALL be ignored; if clr_cmd_rdy and send_resp arrive together in VERT/HORZ, clr_cmd_rdy acts and send_resp is dropped.
REQ-024 cmd format: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-025 Vertical leg opcode 4'h2; horizontal leg opcode 4'h3 (move with fanfare).
REQ-026 Headings: north (+y) 8'h00, west (-x) 8'h3F, south (-y) 8'h7F, east (+x) 8'hBF.
REQ-027 Move decode (bit: dx,dy): 0:-1,+2; 1:+1,+2; 2:-2,+1; 3:-2,-1; 4:-1,-2; 5:+1,-2; 6:+2,-1; 7:+2,+1.
REQ-028 Vertical leg: heading north if dy>0 else south, squares=|dy|; horizontal leg: heading east if dx>0 else west, squares=|dx|.
REQ-029 move not exactly one-hot (zero or multi-bit) SHALL decode to both legs heading 8'h00, squares 4'h0, still issued with the same handshake.
REQ-030 resp SHALL be 8'hA5 in IDLE and in WAIT_H when mv_indx==23, else 8'h5A.
REQ-031 move SHALL be sampled combinationally from input in VERT and HORZ; no internal copy required, solver holds move while mv_indx stable.
REQ-032 mv_indx SHALL change only on IDLE->FETCH and WAIT_H->FETCH transitions.

Reset
REQ-033 rst=1 SHALL force state IDLE and mv_indx 0 on the next clk edge, from any state including mid-tour.
REQ-034 Post-reset outputs: cmd_rdy=cmd_rdy_UART, cmd=cmd_UART, resp=8'hA5, clr_cmd_rdy_UART=clr_cmd_rdy.
REQ-035 rst SHALL take priority over start_tour, clr_cmd_rdy and send_resp in the same cycle.

Verification
REQ-036 Pass-through: IDLE, cmd_UART=16'h2013, cmd_rdy_UART=1, pulse clr_cmd_rdy -> cmd=16'h2013, cmd_rdy=1, clr_cmd_rdy_UART pulses same cycle, resp=8'hA5.
REQ-037 Single move: start_tour, move=8'h02 -> after FETCH cmd=16'h2002 (N,2); clr/send_resp -> cmd=16'h3BF1 (E,1); resp=8'h5A.
REQ-038 Full tour: 24 moves driven from model, each handshake completed -> 48 cmds exact in order, mv_indx 0..23, resp=8'hA5 in final WAIT_H, return to IDLE.
REQ-039 Decode sweep: moves 8'h01..8'h80 -> vertical/horizontal cmds match REQ-027/028 table (e.g. 8'h08 -> 16'h27F1, 16'h33F2).
REQ-040 Illegal move=8'h03 -> cmds 16'h2000 and 16'h3000; stray send_resp in VERT and start_tour mid-tour ignored.
REQ-041 rst asserted in WAIT_V at mv_indx=7 -> next clk IDLE, mv_indx=0, pass-through active, resp=8'hA5.
